aes128_enc_iter: RTL



---
 rtl/aes_pkg.sv | 74 +++++++
 rtl/aes_sbox.sv | 37 +++
 rtl/aes128_enc_iter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared definitions for the iterative AES-128 encryptor:
//                round constants, state byte helpers, GF(2^8) xtime and
//                MixColumns column function, ShiftRows source map and the
//                FSM state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package aes_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } enc_state_t;

    // Round constant for rounds 1..10; anything else returns 0.
    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        logic [7:0] v;
        case (rnd)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1B;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    // Byte i of a 128-bit state; byte 0 occupies bits [127:120].
    // The low bit of byte i sits at 8*(15-i), i.e. {~i,3'b000}.
    function automatic logic [7:0] get_byte(input logic [127:0] s, input logic [3:0] i);
        return s[{~i, 3'b000} +: 8];
    endfunction

    // ShiftRows: output byte at (row r, column c) comes from input
    // (row r, column c+r mod 4). State is column-major, index = 4*c + r.
    function automatic logic [3:0] sr_src(input logic [3:0] i);
        logic [1:0] r;
        logic [1:0] c;
        r = i[1:0];
        c = i[3:2];
        return {2'(c + r), r};
    endfunction

    // Multiply by x in GF(2^8) modulo 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
    endfunction

    // One MixColumns column; row 0 is the top byte.
    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
//  Module      : aes_sbox
//  Description : Combinational AES forward S-box lookup (256 x 8 ROM).
//  Ports       : i_in  - input byte
//                o_out - substituted byte
//  Revision    : 1.0  initial release
// ============================================================================
module aes_sbox (
    input  logic [7:0] i_in,
    output logic [7:0] o_out
);

    // Entry 0 is the most significant byte of the table.
    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign o_out = c_SBOX[{~i_in, 3'b000} +: 8];

endmodule
`default_nettype wire

// File: rtl/aes128_enc_iter.sv
`default_nettype none
// ============================================================================
//  Module      : aes128_enc_iter
//  Description : Iterative AES-128 encryptor, one round per clock, with
//                valid/ready handshakes on input and output.
//  Parameters  : NUM_ROUNDS - 1..10 rounds (10 = FIPS-197 AES-128).
//  Ports       : clk, rst (async, active-high)
//                in_valid / in_ready / plaintext / key0  - block offer
//                out_valid / out_ready / ciphertext / key10 - result
//  Macro       : AES_ENC_KEY10_OUT_EN - when defined, key10 carries the
//                final round key; otherwise key10 is tied to zero.
//  Revision    : 1.0  initial release
// ============================================================================
module aes128_enc_iter
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    input  logic [127:0] key0,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ciphertext,
    output logic [127:0] key10
);

    localparam logic [3:0] c_LAST_RND = 4'(NUM_ROUNDS);

    enc_state_t   r_fsm;
    logic [3:0]   r_rnd;
    logic [127:0] r_state;
    logic [127:0] r_rk;
    logic [127:0] r_ct;

    logic [7:0]   w_sb [16];
    logic [127:0] w_sr;
    logic [127:0] w_mc;
    logic [127:0] w_state_next;
    logic [31:0]  w_rot;
    logic [31:0]  w_sub;
    logic [31:0]  w_k4, w_k5, w_k6, w_k7;
    logic [127:0] w_rk_next;
    logic         w_accept;

    // ---------------- round datapath ----------------
    generate
        for (genvar i = 0; i < 16; i++) begin : g_subbytes
            aes_sbox u_sbox (
                .i_in  (get_byte(r_state, 4'(i))),
                .o_out (w_sb[i])
            );
        end

        for (genvar i = 0; i < 16; i++) begin : g_shiftrows
            assign w_sr[127-8*i -: 8] = w_sb[sr_src(4'(i))];
        end

        for (genvar c = 0; c < 4; c++) begin : g_mixcols
            assign w_mc[127-32*c -: 32] = mix_col(w_sr[127-32*c -: 32]);
        end
    endgenerate

    // The final round skips MixColumns.
    assign w_state_next = ((r_rnd == c_LAST_RND) ? w_sr : w_mc) ^ w_rk_next;

    // ---------------- key schedule ----------------
    assign w_rot = {r_rk[23:0], r_rk[31:24]};

    generate
        for (genvar j = 0; j < 4; j++) begin : g_subword
            aes_sbox u_sbox (
                .i_in  (w_rot[31-8*j -: 8]),
                .o_out (w_sub[31-8*j -: 8])
            );
        end
    endgenerate

    assign w_k4      = r_rk[127:96] ^ w_sub ^ {rcon(r_rnd), 24'h0};
    assign w_k5      = r_rk[95:64]  ^ w_k4;
    assign w_k6      = r_rk[63:32]  ^ w_k5;
    assign w_k7      = r_rk[31:0]   ^ w_k6;
    assign w_rk_next = {w_k4, w_k5, w_k6, w_k7};

    // ---------------- handshake ----------------
    // A finishing block can be retired and a new one accepted on one edge,
    // so in DONE in_ready follows out_ready (never in_valid).
    assign in_ready  = (r_fsm == S_IDLE) || ((r_fsm == S_DONE) && out_ready);
    assign out_valid = (r_fsm == S_DONE);
    assign w_accept  = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm   <= S_IDLE;
            r_rnd   <= 4'd0;
            r_state <= '0;
            r_rk    <= '0;
            r_ct    <= '0;
        end else if (w_accept) begin
            r_state <= plaintext ^ key0;
            r_rk    <= key0;
            r_rnd   <= 4'd1;
            r_fsm   <= S_ROUND;
        end else begin
            case (r_fsm)
                S_ROUND: begin
                    r_state <= w_state_next;
                    r_rk    <= w_rk_next;
                    r_rnd   <= r_rnd + 4'd1;
                    if (r_rnd == c_LAST_RND) begin
                        r_ct  <= w_state_next;
                        r_fsm <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_fsm <= S_IDLE;
                    end
                end
                default: r_fsm <= S_IDLE;
            endcase
        end
    end

    assign ciphertext = r_ct;

`ifdef AES_ENC_KEY10_OUT_EN
    logic [127:0] r_key10;

    // Captured on the same edge as the ciphertext.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key10 <= '0;
        end else if (!w_accept && (r_fsm == S_ROUND) && (r_rnd == c_LAST_RND)) begin
            r_key10 <= w_rk_next;
        end
    end

    assign key10 = r_key10;
`else
    assign key10 = '0;
`endif

endmodule
`default_nettype wire
